cmd_sequencer: RTL

- System controller between the UART RX/TX parallel interfaces, the register file and the ALU.
- Decodes multi-frame commands arriving over RX:
  - 0xAA: register write
  - 0xBB: register read
  - 0xCC: ALU with operands
  - 0xDD: ALU without operands
- Sequences register-file and ALU accesses, and gates the ALU clock for low power.
- Returns results as bytes on the TX parallel interface.

---
 rtl/cmd_sequencer_if.sv | 47 ++++
 rtl/cmd_sequencer.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/cmd_sequencer_if.sv
// cmd_sequencer_if
//   Bundles the RX, register-file, ALU and TX signals of the command sequencer.
//   The sequencer connects through the master modport. The environment (UART
//   RX/TX, register file, ALU) connects through the slave modport.
//   RX : RX_P_DATA, RX_D_VLD, FRAME_ERR                      (to sequencer)
//   RF : RF_WR_EN, RF_RD_EN, RF_ADDR, RF_WR_DATA             (from sequencer)
//        RF_RD_DATA, RF_RD_VLD                               (to sequencer)
//   ALU: ALU_EN, ALU_FUN, CLK_GATE_EN                        (from sequencer)
//        ALU_OUT, ALU_OUT_VLD                                (to sequencer)
//   TX : TX_P_DATA, TX_D_VLD (from sequencer), TX_BUSY       (to sequencer)
interface cmd_sequencer_if #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4,
   parameter int FUN_WIDTH  = 4
);
   logic [DATA_WIDTH-1:0]   RX_P_DATA;
   logic                    RX_D_VLD;
   logic                    FRAME_ERR;
   logic                    RF_WR_EN;
   logic                    RF_RD_EN;
   logic [ADDR_WIDTH-1:0]   RF_ADDR;
   logic [DATA_WIDTH-1:0]   RF_WR_DATA;
   logic [DATA_WIDTH-1:0]   RF_RD_DATA;
   logic                    RF_RD_VLD;
   logic                    ALU_EN;
   logic [FUN_WIDTH-1:0]    ALU_FUN;
   logic [2*DATA_WIDTH-1:0] ALU_OUT;
   logic                    ALU_OUT_VLD;
   logic                    CLK_GATE_EN;
   logic [DATA_WIDTH-1:0]   TX_P_DATA;
   logic                    TX_D_VLD;
   logic                    TX_BUSY;

   modport master (
      input  RX_P_DATA, RX_D_VLD, FRAME_ERR,
      input  RF_RD_DATA, RF_RD_VLD, ALU_OUT, ALU_OUT_VLD, TX_BUSY,
      output RF_WR_EN, RF_RD_EN, RF_ADDR, RF_WR_DATA,
      output ALU_EN, ALU_FUN, CLK_GATE_EN, TX_P_DATA, TX_D_VLD
   );

   modport slave (
      output RX_P_DATA, RX_D_VLD, FRAME_ERR,
      output RF_RD_DATA, RF_RD_VLD, ALU_OUT, ALU_OUT_VLD, TX_BUSY,
      input  RF_WR_EN, RF_RD_EN, RF_ADDR, RF_WR_DATA,
      input  ALU_EN, ALU_FUN, CLK_GATE_EN, TX_P_DATA, TX_D_VLD
   );
endinterface

// File: rtl/cmd_sequencer.sv
// cmd_sequencer
//   System controller between UART RX/TX, register file and ALU. Decodes
//   multi-frame commands (0xAA write, 0xBB read, 0xCC ALU with operands,
//   0xDD ALU without operands). It sequences the register-file and ALU
//   strobes, gates the ALU clock, and returns results as bytes on TX.
//   Ports:
//     CLK - rising-edge system clock
//     RST - synchronous active-low reset; clears all outputs, state to IDLE
//     bus - cmd_sequencer_if.master (RX, RF, ALU and TX signal groups)
module cmd_sequencer #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4,
   parameter int FUN_WIDTH  = 4
) (
   input logic            CLK,
   input logic            RST,
   cmd_sequencer_if.master bus
);

   localparam logic [DATA_WIDTH-1:0] CMD_WR      = DATA_WIDTH'(8'hAA);
   localparam logic [DATA_WIDTH-1:0] CMD_RD      = DATA_WIDTH'(8'hBB);
   localparam logic [DATA_WIDTH-1:0] CMD_ALU_OP  = DATA_WIDTH'(8'hCC);
   localparam logic [DATA_WIDTH-1:0] CMD_ALU_NOP = DATA_WIDTH'(8'hDD);

   typedef enum logic [3:0] {
      IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OP_A, OP_B, FUN,
      ALU_START, ALU_WAIT, TX_REQ, TX_ACK, TX_DONE
   } state_t;

   state_t                  state;
   logic [ADDR_WIDTH-1:0]   addr_lat;
   logic [2*DATA_WIDTH-1:0] resp;
   logic                    two_byte;  // response has a high byte to send
   logic                    hi_sel;    // currently sending the high byte
   logic                    rx_ok;
   logic                    rx_bad;

   always_comb begin
      rx_ok  = bus.RX_D_VLD & ~bus.FRAME_ERR;
      rx_bad = bus.RX_D_VLD &  bus.FRAME_ERR;
   end

   always_ff @(posedge CLK) begin
      if (!RST) begin
         state           <= IDLE;
         addr_lat        <= '0;
         resp            <= '0;
         two_byte        <= 1'b0;
         hi_sel          <= 1'b0;
         bus.RF_WR_EN    <= 1'b0;
         bus.RF_RD_EN    <= 1'b0;
         bus.RF_ADDR     <= '0;
         bus.RF_WR_DATA  <= '0;
         bus.ALU_EN      <= 1'b0;
         bus.ALU_FUN     <= '0;
         bus.CLK_GATE_EN <= 1'b0;
         bus.TX_P_DATA   <= '0;
         bus.TX_D_VLD    <= 1'b0;
      end else begin
         // Strobes default low so each assertion below lasts one cycle.
         bus.RF_WR_EN <= 1'b0;
         bus.RF_RD_EN <= 1'b0;
         bus.ALU_EN   <= 1'b0;
         bus.TX_D_VLD <= 1'b0;

         case (state)
            IDLE: begin
               if (rx_ok) begin
                  case (bus.RX_P_DATA)
                     CMD_WR:      state <= WR_ADDR;
                     CMD_RD:      state <= RD_ADDR;
                     CMD_ALU_OP:  state <= OP_A;
                     CMD_ALU_NOP: state <= FUN;
                     default:     state <= IDLE;
                  endcase
               end
            end
            WR_ADDR: begin
               if (rx_bad) begin
                  state <= IDLE;
               end else if (rx_ok) begin
                  addr_lat <= bus.RX_P_DATA[ADDR_WIDTH-1:0];
                  state    <= WR_DATA;
               end
            end
            WR_DATA: begin
               if (rx_bad) begin
                  state <= IDLE;
               end else if (rx_ok) begin
                  bus.RF_WR_EN   <= 1'b1;
                  bus.RF_ADDR    <= addr_lat;
                  bus.RF_WR_DATA <= bus.RX_P_DATA;
                  state          <= IDLE;
               end
            end
            RD_ADDR: begin
               if (rx_bad) begin
                  state <= IDLE;
               end else if (rx_ok) begin
                  bus.RF_RD_EN <= 1'b1;
                  bus.RF_ADDR  <= bus.RX_P_DATA[ADDR_WIDTH-1:0];
                  state        <= RD_WAIT;
               end
            end
            RD_WAIT: begin
               if (bus.RF_RD_VLD) begin
                  resp     <= {{DATA_WIDTH{1'b0}}, bus.RF_RD_DATA};
                  two_byte <= 1'b0;
                  hi_sel   <= 1'b0;
                  state    <= TX_REQ;
               end
            end
            OP_A: begin
               if (rx_bad) begin
                  state <= IDLE;
               end else if (rx_ok) begin
                  bus.RF_WR_EN   <= 1'b1;
                  bus.RF_ADDR    <= '0;
                  bus.RF_WR_DATA <= bus.RX_P_DATA;
                  state          <= OP_B;
               end
            end
            OP_B: begin
               if (rx_bad) begin
                  state <= IDLE;
               end else if (rx_ok) begin
                  bus.RF_WR_EN   <= 1'b1;
                  bus.RF_ADDR    <= ADDR_WIDTH'(1);
                  bus.RF_WR_DATA <= bus.RX_P_DATA;
                  state          <= FUN;
               end
            end
            FUN: begin
               if (rx_bad) begin
                  state <= IDLE;
               end else if (rx_ok) begin
                  bus.ALU_FUN     <= bus.RX_P_DATA[FUN_WIDTH-1:0];
                  bus.CLK_GATE_EN <= 1'b1;
                  state           <= ALU_START;
               end
            end
            // One cycle with the gate open before the strobe lets the gated
            // ALU clock settle.
            ALU_START: begin
               bus.ALU_EN <= 1'b1;
               state      <= ALU_WAIT;
            end
            ALU_WAIT: begin
               if (bus.ALU_OUT_VLD) begin
                  resp            <= bus.ALU_OUT;
                  bus.CLK_GATE_EN <= 1'b0;
                  two_byte        <= 1'b1;
                  hi_sel          <= 1'b0;
                  state           <= TX_REQ;
               end
            end
            TX_REQ: begin
               if (!bus.TX_BUSY) begin
                  bus.TX_D_VLD  <= 1'b1;
                  bus.TX_P_DATA <= hi_sel ? resp[2*DATA_WIDTH-1:DATA_WIDTH]
                                          : resp[DATA_WIDTH-1:0];
                  state         <= TX_ACK;
               end
            end
            TX_ACK: begin
               if (bus.TX_BUSY) state <= TX_DONE;
            end
            TX_DONE: begin
               if (!bus.TX_BUSY) begin
                  if (two_byte && !hi_sel) begin
                     hi_sel <= 1'b1;
                     state  <= TX_REQ;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
